// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: operation codes, FSM states,
// multi-cycle op kinds and the iteration-counter width.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SLT = 3'b011,
    OP_SLL = 3'b100,
    OP_SRL = 3'b101,
    OP_MUL = 3'b110,
    OP_RSV = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    RK_SLL = 2'd0,
    RK_SRL = 2'd1,
    RK_MUL = 2'd2
  } run_e;

  // One extra bit so the counter can hold WIDTH itself for a full multiply.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle of the sequential ALU; master drives the request,
// slave (the ALU) drives status and results.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic             ainvert;
  logic             binvert;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             ovf;
  logic             cout;

  modport master (
    output start, op, ainvert, binvert, a, b,
    input  busy, done, result, zero, ovf, cout
  );

  modport slave (
    input  start, op, ainvert, binvert, a, b,
    output busy, done, result, zero, ovf, cout
  );
endinterface

// File: rtl/alu_core.sv
// Combinational ALU slice: operand inversion, AND/OR, ripple-free adder and
// set-less-than derived from the adder's sign and overflow.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             ainvert_i,
  input  logic             binvert_i,
  input  op_e              op_i,
  output logic [WIDTH-1:0] a_eff_o,
  output logic [WIDTH-1:0] b_eff_o,
  output logic [WIDTH-1:0] res_o,
  output logic             ovf_o,
  output logic             cout_o
);

  logic [WIDTH-1:0] a_eff;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   add_full;
  logic             carry_msb;
  logic             add_ovf;
  logic             slt_set;

  always_comb begin
    a_eff     = ainvert_i ? ~a_i : a_i;
    b_eff     = binvert_i ? ~b_i : b_i;
    add_full  = {1'b0, a_eff} + {1'b0, b_eff} + {{WIDTH{1'b0}}, binvert_i};
    // Carry into the MSB recovered from the MSB sum bit and its operands.
    carry_msb = a_eff[WIDTH-1] ^ b_eff[WIDTH-1] ^ add_full[WIDTH-1];
    add_ovf   = carry_msb ^ add_full[WIDTH];
    slt_set   = add_full[WIDTH-1] ^ add_ovf;

    res_o  = '0;
    ovf_o  = 1'b0;
    cout_o = 1'b0;
    case (op_i)
      OP_AND: res_o = a_eff & b_eff;
      OP_OR:  res_o = a_eff | b_eff;
      OP_ADD: begin
        res_o  = add_full[WIDTH-1:0];
        ovf_o  = add_ovf;
        cout_o = add_full[WIDTH];
      end
      OP_SLT: res_o = {{(WIDTH-1){1'b0}}, slt_set};
      default: res_o = '0;
    endcase
  end

  assign a_eff_o = a_eff;
  assign b_eff_o = b_eff;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops through alu_core, plus
// bit-serial shifts and shift-add multiply run by a two-state FSM.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave alu_if
);

  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = cnt_width(WIDTH);

  op_e              op_in;
  logic [WIDTH-1:0] a_eff;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] core_res;
  logic             core_ovf;
  logic             core_cout;
  logic [SH_W-1:0]  shamt;
  logic             accept;

  state_e           state_q, state_d;
  run_e             kind_q, kind_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             cout_q, cout_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] mb_q, mb_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  assign op_in = op_e'(alu_if.op);
  assign shamt = b_eff[SH_W-1:0];
  // Start is refused during a done cycle so done can never stay high twice.
  assign accept = alu_if.start && (state_q == ST_IDLE) && !done_q;

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a_i       (alu_if.a),
    .b_i       (alu_if.b),
    .ainvert_i (alu_if.ainvert),
    .binvert_i (alu_if.binvert),
    .op_i      (op_in),
    .a_eff_o   (a_eff),
    .b_eff_o   (b_eff),
    .res_o     (core_res),
    .ovf_o     (core_ovf),
    .cout_o    (core_cout)
  );

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    result_d = result_q;
    ovf_d    = ovf_q;
    cout_d   = cout_q;
    sh_d     = sh_q;
    mb_d     = mb_q;
    acc_d    = acc_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (op_in)
            OP_SLL, OP_SRL: begin
              if (shamt == '0) begin
                result_d = a_eff;
                ovf_d    = 1'b0;
                cout_d   = 1'b0;
                done_d   = 1'b1;
              end else begin
                sh_d    = a_eff;
                cnt_d   = CNT_W'(shamt);
                kind_d  = (op_in == OP_SLL) ? RK_SLL : RK_SRL;
                state_d = ST_RUN;
              end
            end
            OP_MUL: begin
              sh_d    = a_eff;
              mb_d    = b_eff;
              acc_d   = '0;
              cnt_d   = CNT_W'(WIDTH);
              kind_d  = RK_MUL;
              state_d = ST_RUN;
            end
            default: begin
              result_d = core_res;
              ovf_d    = core_ovf;
              cout_d   = core_cout;
              done_d   = 1'b1;
            end
          endcase
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        case (kind_q)
          RK_SLL: sh_d = sh_q << 1;
          RK_SRL: sh_d = sh_q >> 1;
          default: begin
            acc_d = mb_q[0] ? (acc_q + sh_q) : acc_q;
            sh_d  = sh_q << 1;
            mb_d  = mb_q >> 1;
          end
        endcase
        if (cnt_q == CNT_W'(1)) begin
          state_d  = ST_IDLE;
          done_d   = 1'b1;
          result_d = (kind_q == RK_MUL) ? acc_d : sh_d;
          ovf_d    = 1'b0;
          cout_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      kind_q   <= RK_SLL;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      cout_q   <= cout_d;
    end
  end

  // Working operands are only meaningful while RUN, so they carry no reset.
  always_ff @(posedge clk) begin
    sh_q  <= sh_d;
    mb_q  <= mb_d;
    acc_q <= acc_d;
  end

  assign alu_if.busy   = (state_q == ST_RUN);
  assign alu_if.done   = done_q;
  assign alu_if.result = result_q;
  assign alu_if.zero   = zero_q;
  assign alu_if.ovf    = ovf_q;
  assign alu_if.cout   = cout_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized bench for alu_seq (WIDTH=8) against an arithmetic reference model.
`timescale 1ns/1ps
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   last_lat;

  alu_seq_if #(.WIDTH(8)) bus ();

  alu_seq #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .alu_if (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the effective operands.
  task automatic model(input logic [2:0] op, input logic ai, input logic bi,
                       input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] r, output logic ov, output logic co,
                       output int lat);
    logic [7:0] ea, eb;
    int ua, ub, sa, sb, s, ss, k;
    ea = ai ? ~a : a;
    eb = bi ? ~b : b;
    ua = int'(ea);
    ub = int'(eb);
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    k  = ub % 8;
    r = 8'h00; ov = 1'b0; co = 1'b0; lat = 1;
    case (op)
      3'd0: r = ea & eb;
      3'd1: r = ea | eb;
      3'd2: begin
        s  = ua + ub + int'(bi);
        ss = sa + sb + int'(bi);
        r  = 8'(s);
        co = (s > 255);
        ov = (ss > 127) || (ss < -128);
      end
      3'd3: r = ((sa + sb + int'(bi)) < 0) ? 8'h01 : 8'h00;
      3'd4: begin r = 8'(ua << k); lat = (k == 0) ? 1 : k + 1; end
      3'd5: begin r = 8'(ua >> k); lat = (k == 0) ? 1 : k + 1; end
      3'd6: begin r = 8'(ua * ub); lat = 9; end
      default: r = 8'h00;
    endcase
  endtask

  task automatic exec(input string tag, input logic [2:0] op, input logic ai, input logic bi,
                      input logic [7:0] a, input logic [7:0] b);
    logic [7:0] er, prev;
    logic       eo, ec, held;
    int         el, lat, busy_n;
    model(op, ai, bi, a, b, er, eo, ec, el);
    prev = bus.result;
    @(negedge clk);
    bus.op = op; bus.ainvert = ai; bus.binvert = bi; bus.a = a; bus.b = b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a = 8'($urandom); bus.b = 8'($urandom); bus.op = 3'($urandom);
    bus.ainvert = 1'($urandom); bus.binvert = 1'($urandom);
    lat = 1; busy_n = 0; held = 1'b1;
    while (!bus.done && lat < 40) begin
      if (bus.busy) busy_n++;
      if (bus.result !== prev) held = 1'b0;
      bus.start = bus.busy ? 1'($urandom % 2) : 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    last_lat = lat;
    chk({tag, "_lat"},  32'(lat), 32'(el));
    chk({tag, "_res"},  32'(bus.result), 32'(er));
    chk({tag, "_zero"}, 32'(bus.zero), 32'(er == 8'h00));
    chk({tag, "_ovf"},  32'(bus.ovf), 32'(eo));
    chk({tag, "_cout"}, 32'(bus.cout), 32'(ec));
    chk({tag, "_busyn"}, 32'(busy_n), 32'(el - 1));
    chk({tag, "_held"}, 32'(held), 32'd1);
    chk({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_done_drop"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    logic seen_done;
    bus.start = 1'b0; bus.op = 3'd0; bus.ainvert = 1'b0; bus.binvert = 1'b0;
    bus.a = 8'h00; bus.b = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",   32'(bus.busy), 32'd0);
    chk("rst_done",   32'(bus.done), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_zero",   32'(bus.zero), 32'd1);
    chk("rst_ovf",    32'(bus.ovf), 32'd0);
    chk("rst_cout",   32'(bus.cout), 32'd0);
    @(negedge clk); rst = 1'b0;

    exec("add7f", 3'd2, 1'b0, 1'b0, 8'h7F, 8'h01);
    chk("add7f_c", 32'(bus.result), 32'h80);
    chk("add7f_ovf_c", 32'(bus.ovf), 32'd1);
    chk("add7f_lat_c", 32'(last_lat), 32'd1);
    exec("slt57", 3'd3, 1'b0, 1'b1, 8'd5, 8'd7);
    chk("slt57_c", 32'(bus.result), 32'h01);
    exec("slt75", 3'd3, 1'b0, 1'b1, 8'd7, 8'd5);
    chk("slt75_c", 32'(bus.result), 32'h00);
    chk("slt75_zero_c", 32'(bus.zero), 32'd1);
    exec("nor", 3'd0, 1'b1, 1'b1, 8'hF0, 8'h0F);
    chk("nor_c", 32'(bus.result), 32'h00);
    exec("sll3", 3'd4, 1'b0, 1'b0, 8'h01, 8'd3);
    chk("sll3_c", 32'(bus.result), 32'h08);
    chk("sll3_lat_c", 32'(last_lat), 32'd4);
    exec("srl0", 3'd5, 1'b0, 1'b0, 8'h80, 8'd0);
    chk("srl0_c", 32'(bus.result), 32'h80);
    exec("rsv", 3'd7, 1'b0, 1'b0, 8'hFF, 8'hFF);
    chk("rsv_c", 32'(bus.result), 32'h00);
    exec("mul", 3'd6, 1'b0, 1'b0, 8'd12, 8'd11);
    chk("mul_c", 32'(bus.result), 32'h84);
    chk("mul_lat_c", 32'(last_lat), 32'd9);

    for (int i = 0; i < 200; i++)
      exec("rnd", 3'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));

    // Make result nonzero, then abort a multiply in its fourth cycle.
    exec("pre", 3'd1, 1'b0, 1'b0, 8'h5A, 8'h00);
    @(negedge clk);
    bus.op = 3'd6; bus.ainvert = 1'b0; bus.binvert = 1'b0;
    bus.a = 8'd12; bus.b = 8'd11; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("abort_busy_pre", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_busy",   32'(bus.busy), 32'd0);
    chk("abort_done",   32'(bus.done), 32'd0);
    chk("abort_result", 32'(bus.result), 32'd0);
    chk("abort_zero",   32'(bus.zero), 32'd1);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) seen_done = 1'b1;
    end
    chk("abort_no_done", 32'(seen_done), 32'd0);
    exec("add34", 3'd2, 1'b0, 1'b0, 8'd3, 8'd4);
    chk("add34_c", 32'(bus.result), 32'h07);
    chk("add34_lat_c", 32'(last_lat), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits (legal range 4..64, power of two).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port op  input  3  operation: 000 AND, 001 OR, 010 ADD, 011 SLT, 100 SLL, 101 SRL, 110 MUL, 111 reserved.
REQ-006 SHALL have ports ainvert, binvert  input  1 each  invert a / b before use; binvert also serves as adder carry-in.
REQ-007 SHALL have ports a, b  input  WIDTH each  operands.
REQ-008 SHALL have port busy  output  1  high while a multi-cycle op runs.
REQ-009 SHALL have port done  output  1  one-cycle pulse when result updates.
REQ-010 SHALL have port result  output  WIDTH  registered result.
REQ-011 SHALL have ports zero, ovf, cout  output  1 each  registered flags.

Function
REQ-012 SHALL form A = ainvert ? ~a : a and B = binvert ? ~b : b for every op, captured into registers on accepted start.
REQ-013 SHALL accept start only in IDLE; start while busy or in a done cycle with busy low is accepted only if state is IDLE, otherwise ignored without effect.
REQ-014 Single-cycle ops (AND, OR, ADD, SLT, reserved, SLL/SRL with shift amount 0) SHALL update result and pulse done on the clock edge after the start edge (latency 1).
REQ-015 ADD SHALL compute A + B + binvert modulo 2^WIDTH; cout = carry out of MSB; ovf = carry into MSB XOR carry out of MSB.
REQ-016 SLT SHALL compute set = sum[WIDTH-1] XOR ovf of the ADD above; result = {WIDTH-1 zeros, set}; ovf and cout reported 0.
REQ-017 SLL/SRL SHALL shift A by B[log2(WIDTH)-1:0] one bit per cycle, zero fill; shift amount k>0 gives done k+1 cycles after start edge.
REQ-018 MUL SHALL compute low WIDTH bits of A*B (unsigned) by shift-add, one multiplier bit per cycle; done exactly WIDTH+1 cycles after start edge.
REQ-019 Reserved op SHALL give result 0 with latency 1.
REQ-020 ovf and cout SHALL be 0 for all ops except ADD; zero SHALL equal (result == 0) and update with result.
REQ-021 State machine SHALL be IDLE -> RUN (multi-cycle op accepted) -> IDLE at completion; single-cycle ops stay in IDLE; busy = (state == RUN).
REQ-022 result and flags SHALL hold their last value between completions; done SHALL never be high for two consecutive cycles.
REQ-023 Iteration counter SHALL be log2(WIDTH)+1 bits and SHALL not wrap during a legal operation.
REQ-024 Input changes on a, b, op, ainvert, binvert after the start edge SHALL not affect the running operation.

Reset
REQ-025 rst high SHALL immediately force state IDLE, busy 0, done 0, result 0, zero 1, ovf 0, cout 0, counter 0, regardless of clock.
REQ-026 Reset asserted mid-operation SHALL abort it with no done pulse; first start after rst deasserts SHALL behave as from power-up.

Structure
REQ-027 Op encodings, state encoding and a WIDTH-derived counter-width constant SHALL live in shared package alu_pkg.
REQ-028 Combinational invert/logic/adder/SLT datapath SHALL be sub-module alu_core (WIDTH-parametrised); alu_seq holds FSM, shift and multiply registers.

Verification (WIDTH=8)
REQ-029 ADD a=8'h7F b=8'h01 inverts 0 -> one cycle later result 8'h80, ovf 1, cout 0, zero 0, done 1 for one cycle.
REQ-030 SLT a=5 b=7 binvert=1 -> result 8'h01; repeat a=7 b=5 -> result 8'h00, zero 1.
REQ-031 AND a=8'hF0 b=8'h0F ainvert=1 binvert=1 (NOR) -> result 8'h00, zero 1, latency 1.
REQ-032 MUL a=12 b=11 -> busy high 8 cycles, done at cycle 9, result 8'h84; start pulses during busy ignored, result unchanged until done.
REQ-033 SLL a=8'h01 b=3 -> done 4 cycles after start, result 8'h08; SRL a=8'h80 b=0 -> done after 1 cycle, result 8'h80.
REQ-034 Assert rst during cycle 4 of MUL -> busy, done, result drop to 0 asynchronously, no done pulse; subsequent ADD 3+4 -> result 8'h07 with latency 1.
